// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// It issues one op at a time, waits a command-dependent latency and returns the result over a response handshake.
module alu_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_mode,
  input  logic [1:0]           req_cin,
  input  logic [7:0]           req_cmd,
  input  logic [2*WIDTH-1:0]   req_opa,
  input  logic [2*WIDTH-1:0]   req_opb,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH:0]       rsp_res,
  output logic [5:0]           rsp_flags,
  output logic                 alu_ce,
  output logic                 alu_mode,
  output logic                 alu_cin,
  output logic [1:0]           alu_inp_valid,
  output logic [3:0]           alu_cmd,
  output logic [WIDTH-1:0]     alu_opa,
  output logic [WIDTH-1:0]     alu_opb,
  input  logic [WIDTH:0]       alu_res,
  input  logic                 alu_err,
  input  logic                 alu_oflow,
  input  logic                 alu_cout,
  input  logic                 alu_g,
  input  logic                 alu_l,
  input  logic                 alu_e
);

  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic            ptr;
  logic            gnt;
  logic [CW-1:0]   cnt;

  logic            sel;
  logic            sel_mode;
  logic            sel_cin;
  logic [3:0]      sel_cmd;
  logic [WIDTH-1:0] sel_opa;
  logic [WIDTH-1:0] sel_opb;
  logic            accept;

  // Grant goes to the pointer holder, falling back to the other requester.
  always_comb begin
    sel = ptr;
    if (!req_valid[ptr] && req_valid[~ptr]) sel = ~ptr;
    accept    = (state == S_IDLE) && req_valid[sel];
    req_ready = 2'b00;
    if (accept) req_ready[sel] = 1'b1;
    sel_mode = req_mode[sel];
    sel_cin  = req_cin[sel];
    sel_cmd  = sel ? req_cmd[7:4] : req_cmd[3:0];
    sel_opa  = sel ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
    sel_opb  = sel ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ptr           <= 1'b0;
      gnt           <= 1'b0;
      cnt           <= '0;
      rsp_valid     <= 2'b00;
      rsp_res       <= '0;
      rsp_flags     <= 6'b000000;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_inp_valid <= 2'b00;
      alu_cmd       <= 4'd0;
      alu_opa       <= '0;
      alu_opb       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            gnt <= sel;
            if (sel_cmd > 4'd13) begin
              // Illegal command: answer with an error without touching the ALU.
              rsp_res   <= '0;
              rsp_flags <= 6'b100000;
              rsp_valid <= {sel, ~sel};
              state     <= S_RESP;
            end else begin
              alu_ce        <= 1'b1;
              alu_inp_valid <= 2'b11;
              alu_mode      <= sel_mode;
              alu_cin       <= sel_cin;
              alu_cmd       <= sel_cmd;
              alu_opa       <= sel_opa;
              alu_opb       <= sel_opb;
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) cnt <= CW'(MUL_LAT);
          else                                                    cnt <= CW'(ALU_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_ONE) begin
            rsp_res       <= alu_res;
            rsp_flags     <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
            rsp_valid     <= {gnt, ~gnt};
            alu_ce        <= 1'b0;
            alu_inp_valid <= 2'b00;
            state         <= S_RESP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            ptr       <= ~gnt;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a small latency-accurate ALU model.
// The model returns a garbage pattern until the command latency has elapsed since issue.
module tb_alu_req_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [1:0]     req_mode = 2'b00;
  logic [1:0]     req_cin = 2'b00;
  logic [7:0]     req_cmd = 8'h00;
  logic [2*W-1:0] req_opa = '0;
  logic [2*W-1:0] req_opb = '0;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready = 2'b00;
  logic [W:0]     rsp_res;
  logic [5:0]     rsp_flags;
  logic           alu_ce, alu_mode, alu_cin;
  logic [1:0]     alu_inp_valid;
  logic [3:0]     alu_cmd;
  logic [W-1:0]   alu_opa, alu_opb;
  logic [W:0]     alu_res;
  logic           alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cin(req_cin),
    .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
    .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_res(alu_res),
    .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e)
  );

  // ALU model: result only becomes valid once the command latency has passed since issue.
  int         age;
  int         m_lat;
  logic [W:0] m_res;
  logic       m_cout;
  always @(posedge clk or negedge rst) begin
    if (!rst)        age <= 0;
    else if (alu_ce) age <= age + 1;
    else             age <= 0;
  end

  always_comb begin
    m_lat  = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 2 : 1;
    m_cout = 1'b0;
    m_res  = {1'b0, alu_opa ^ alu_opb};
    if (alu_mode && alu_cmd == 4'd0) begin
      m_res  = {1'b0, alu_opa} + {1'b0, alu_opb} + {{W{1'b0}}, alu_cin};
      m_cout = m_res[W];
    end else if (alu_mode && alu_cmd == 4'd9) begin
      m_res = (W+1)'({1'b0, alu_opa} * {1'b0, alu_opb});
    end else if (alu_mode && alu_cmd == 4'd10) begin
      m_res = (W+1)'({alu_opa, 1'b0} * {1'b0, alu_opb});
    end
    if (age >= m_lat) begin
      alu_res = m_res;
      {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} =
        {1'b0, 1'b0, m_cout, alu_opa > alu_opb, alu_opa < alu_opb, alu_opa == alu_opb};
    end else begin
      alu_res = 9'h1AA;
      {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = 6'b010101;
    end
  end

  logic [43:0] all_outs;
  assign all_outs = {req_ready, rsp_valid, rsp_res, rsp_flags, alu_ce, alu_mode, alu_cin,
                     alu_inp_valid, alu_cmd, alu_opa, alu_opb};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
    req_mode[k]        = m;
    req_cin[k]         = ci;
    req_cmd[k*4 +: 4]  = c;
    req_opa[k*W +: W]  = a;
    req_opb[k*W +: W]  = b;
  endtask

  initial begin
    int n0, n1, served, cyc, exp_g;
    logic [1:0] rr, rv;
    logic [W:0] rs;

    #2 rst = 1'b0;
    #10;
    chk("reset_outs", 64'(all_outs), 64'd0);
    #1 rst = 1'b1;

    // Single ADD from requester 0
    step();
    set_req(0, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("add_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    chk("add_issue_ce", 64'({alu_ce, alu_inp_valid}), 64'h7);
    chk("add_issue_ops", 64'({alu_mode, alu_cmd, alu_opa, alu_opb}), 64'h1_0_FF_01);
    chk("add_issue_rspv", 64'(rsp_valid), 64'h0);
    step();
    chk("add_wait_ce", 64'(alu_ce), 64'h1);
    step();
    chk("add_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("add_rsp_res", 64'(rsp_res), 64'h100);
    chk("add_rsp_flags", 64'(rsp_flags), 64'b001100);
    chk("add_rsp_ce", 64'({alu_ce, alu_inp_valid}), 64'h0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("add_done", 64'(rsp_valid), 64'h0);

    // Multiply from requester 1 with the longer latency
    set_req(1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
    req_valid = 2'b10;
    #1;
    chk("mul_req_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00;
    chk("mul_issue", 64'({alu_ce, alu_cmd}), 64'h19);
    step();
    chk("mul_wait1", 64'(rsp_valid), 64'h0);
    step();
    chk("mul_wait2", 64'(rsp_valid), 64'h0);
    step();
    chk("mul_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("mul_rsp_res", 64'(rsp_res), 64'h00C);
    chk("mul_rsp_flags", 64'(rsp_flags), 64'b000010);
    rsp_ready = 2'b01;
    step();
    chk("mul_other_ready_ignored", 64'(rsp_valid), 64'h2);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    chk("mul_done", 64'(rsp_valid), 64'h0);

    // Illegal command from requester 0
    set_req(0, 1'b0, 4'hF, 8'h12, 8'h34, 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("ill_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("ill_rsp_res", 64'(rsp_res), 64'h0);
    chk("ill_rsp_flags", 64'(rsp_flags), 64'b100000);
    chk("ill_alu_untouched", 64'({alu_ce, alu_inp_valid, alu_cmd}), 64'h09);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("ill_done", 64'(rsp_valid), 64'h0);

    // Backpressure on a requester 1 ADD while both requesters wait
    set_req(1, 1'b1, 4'd0, 8'd5, 8'd6, 1'b0);
    req_valid = 2'b10;
    step();
    set_req(0, 1'b1, 4'd0, 8'd1, 8'd16, 1'b0);
    set_req(1, 1'b1, 4'd0, 8'd1, 8'd32, 1'b0);
    req_valid = 2'b11;
    step();
    chk("bp_ready_busy", 64'(req_ready), 64'h0);
    step();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("bp_rsp_res", 64'(rsp_res), 64'h00B);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", 64'({rsp_valid, rsp_res, rsp_flags, req_ready}), 64'({2'b10, 9'h00B, 6'b000010, 2'b00}));
    end
    rsp_ready = 2'b11;
    step();
    chk("bp_release", 64'(rsp_valid), 64'h0);
    chk("bp_ptr_flip", 64'(req_ready), 64'h1);

    // Continuous contention: 4 ops each, strict alternation starting at requester 0
    n0 = 0; n1 = 0; served = 0; cyc = 0;
    while (served < 8 && cyc < 200) begin
      rr = req_ready;
      rv = rsp_valid;
      rs = rsp_res;
      step();
      cyc++;
      if (rr[0]) begin
        n0++;
        if (n0 < 4) set_req(0, 1'b1, 4'd0, 8'(n0 + 1), 8'd16, 1'b0);
        else        req_valid[0] = 1'b0;
      end
      if (rr[1]) begin
        n1++;
        if (n1 < 4) set_req(1, 1'b1, 4'd0, 8'(n1 + 1), 8'd32, 1'b0);
        else        req_valid[1] = 1'b0;
      end
      if (rv != 2'b00) begin
        exp_g = served % 2;
        chk("cont_grant", 64'(rv), (exp_g == 1) ? 64'h2 : 64'h1);
        chk("cont_res", 64'(rs), 64'(((exp_g == 1) ? 33 : 17) + served / 2));
        served++;
      end
    end
    chk("cont_served", 64'(served), 64'd8);
    chk("cont_cycles", 64'(cyc), 64'd32);

    // Reset in the middle of WAIT: flip the pointer to 1 first
    set_req(0, 1'b1, 4'd0, 8'd2, 8'd3, 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    chk("pre_rst_idle", 64'(rsp_valid), 64'h0);
    set_req(1, 1'b1, 4'd9, 8'd7, 8'd7, 1'b0);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    chk("pre_rst_wait_ce", 64'(alu_ce), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outs", 64'(all_outs), 64'd0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_rsp", 64'(rsp_valid), 64'h0);
    end
    req_valid = 2'b11;
    #1;
    chk("rst_ptr_zero", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU between two requesters (index 0, 1) using round-robin arbitration.
- Accepts one operation at a time over a valid/ready handshake, drives the ALU input ports, and waits a command-dependent latency.
- Captures res and the flags, then returns them to the granted requester over a valid/ready response handshake.
- Sits between the stimulus/command sources and the ALU datapath.

Parameters:
- WIDTH, 8, operand width; res is WIDTH+1 bits.
- ALU_LAT, 1, cycles from the issue edge to a valid ALU result for ordinary commands (≥1).
- MUL_LAT, 2, cycles from the issue edge to a valid ALU result for mode=1, cmd 9 or 10 (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept
- req_mode  in  2  mode bit per requester
- req_cin  in  2  carry-in per requester
- req_cmd  in  8  {cmd1[3:0], cmd0[3:0]}
- req_opa  in  2*WIDTH  {opa1, opa0}
- req_opb  in  2*WIDTH  {opb1, opb0}
- rsp_valid  out  2  one-hot response valid
- rsp_ready  in  2  per-requester response accept
- rsp_res  out  WIDTH+1  captured result
- rsp_flags  out  6  {err, oflow, cout, g, l, e}
- alu_ce, alu_mode, alu_cin  out  1 each  to ALU
- alu_inp_valid  out  2  to ALU
- alu_cmd  out  4  to ALU
- alu_opa, alu_opb  out  WIDTH each  to ALU
- alu_res  in  WIDTH+1  from ALU
- alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  from ALU

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; priority pointer=0 (requester 0 favoured).
  - All outputs 0: req_ready, rsp_valid, rsp_res, rsp_flags, every alu_* output.
  - Asserting rst mid-operation abandons the operation; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = pointer if req_valid[pointer], else the other requester if its valid is high.
  - req_ready[g]=1 combinationally; the other req_ready bit is 0.
  - On req_valid[g] & req_ready[g], register mode/cin/cmd/opa/opb and g.
  - If the command is legal, go to ISSUE.
  - Illegal command (cmd > 13 in either mode): go directly to RESP with rsp_res=0 and rsp_flags=6'b100000. The ALU is not touched.
  - No req_valid: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_ce=1, alu_inp_valid=2'b11; alu_mode/cmd/cin/opa/opb = registered values.
  - Load the latency counter with MUL_LAT when mode=1 and cmd∈{9,10}, else with ALU_LAT.
  - Go to WAIT.
- WAIT:
  - alu_ce=1; alu_inp_valid=2'b11; operand and cmd outputs held stable.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, sample alu_res and the flags into rsp_res/rsp_flags at that edge. The sample lands exactly LAT rising edges after the ISSUE edge.
  - Then go to RESP.
- RESP:
  - alu_ce=0, alu_inp_valid=2'b00; operand outputs keep their last values.
  - rsp_valid[g]=1; rsp_res/rsp_flags stable until the handshake completes.
  - On rsp_ready[g], clear rsp_valid, set pointer = ~g, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- req_ready is 0 in every state except IDLE. Requests arriving in other states wait; valid must be held by the requester.
- Simultaneous requests in IDLE: the pointer holder wins. After service the other requester wins the next tie, so strict alternation holds under continuous contention.
- Response-to-next-request: a new request may be accepted in the cycle after the response handshake (IDLE), never in the same cycle.
- Throughput: ALU_LAT+3 cycles per op with rsp_ready tied high.

Test Plan:
- Reset: rst low mid-WAIT → all outputs 0 next sample, state IDLE, no rsp_valid after release; the next request from requester 0 is accepted first.
- Single ADD: req 0, mode=1, cmd=0, opa=8'hFF, opb=8'h01, cin=0 → alu_ce high ISSUE+WAIT, rsp_valid=2'b01 after 3 cycles (ALU_LAT=1), rsp_res=9'h100, cout=1, err=0.
- Contention: both valid continuously, 4 ops each → grants strictly 0,1,0,1,…; no request lost or duplicated.
- Multiply latency: req 1, mode=1, cmd=9, opa=3, opb=4 → result sampled 2 edges after issue, rsp_valid=2'b10, rsp_res matches the ALU model.
- Illegal command: req 0, cmd=4'hF → no alu_ce pulse, rsp_valid=2'b01 the cycle after accept, rsp_flags=6'b100000, rsp_res=0.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid/res/flags stable, req_ready=0 for both requesters; release → IDLE, pointer flips.
